// File: rtl/fair_bus_arbiter_if.sv
// Shared-bus arbitration signals between masters, slaves and the arbiter.
// The arbiter takes the slave modport; requesters and slaves take master.
interface fair_bus_arbiter_if;
    logic       m1_request;
    logic       m2_request;
    logic [1:0] m1_slave_sel;
    logic [1:0] m2_slave_sel;
    logic       trans_done;
    logic       slave_split;
    logic       m1_grant;
    logic       m2_grant;
    logic       arbiter_busy;
    logic [1:0] bus_grant;
    logic [1:0] slave_sel;
    logic       timeout_err;

    modport master (
        output m1_request, m2_request,
        output m1_slave_sel, m2_slave_sel,
        output trans_done, slave_split,
        input  m1_grant, m2_grant, arbiter_busy,
        input  bus_grant, slave_sel, timeout_err
    );

    modport slave (
        input  m1_request, m2_request,
        input  m1_slave_sel, m2_slave_sel,
        input  trans_done, slave_split,
        output m1_grant, m2_grant, arbiter_busy,
        output bus_grant, slave_sel, timeout_err
    );
endinterface

// File: rtl/fair_bus_arbiter.sv
// Two-master bus arbiter: fixed priority to master 1, a starvation guard
// for master 2, and a watchdog that bounds every tenure.
module fair_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input logic              clk,
    input logic              rst_n,
    fair_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    logic [7:0] to_cnt;
    logic [3:0] starve_cnt;
    logic       m2_wins;
    logic       watchdog;
    logic       tenure_end;

    // Master 2 wins when alone or once master 1 has starved it long enough
    assign m2_wins    = bus.m2_request &&
                        (!bus.m1_request || starve_cnt == STARVE_MAX);
    assign watchdog   = to_cnt == TO_LAST;
    assign tenure_end = bus.trans_done || bus.slave_split || watchdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            to_cnt           <= '0;
            starve_cnt       <= '0;
            bus.m1_grant     <= 1'b0;
            bus.m2_grant     <= 1'b0;
            bus.arbiter_busy <= 1'b0;
            bus.bus_grant    <= 2'd0;
            bus.slave_sel    <= 2'd0;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m2_wins) begin
                        state            <= OWN2;
                        to_cnt           <= '0;
                        starve_cnt       <= '0;
                        bus.m2_grant     <= 1'b1;
                        bus.arbiter_busy <= 1'b1;
                        bus.bus_grant    <= 2'd2;
                        bus.slave_sel    <= bus.m2_slave_sel;
                    end else if (bus.m1_request) begin
                        state            <= OWN1;
                        to_cnt           <= '0;
                        bus.m1_grant     <= 1'b1;
                        bus.arbiter_busy <= 1'b1;
                        bus.bus_grant    <= 2'd1;
                        bus.slave_sel    <= bus.m1_slave_sel;
                        if (bus.m2_request && starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                OWN1, OWN2: begin
                    if (tenure_end) begin
                        state            <= IDLE;
                        bus.m1_grant     <= 1'b0;
                        bus.m2_grant     <= 1'b0;
                        bus.arbiter_busy <= 1'b0;
                        bus.bus_grant    <= 2'd0;
                        bus.slave_sel    <= 2'd0;
                        // Only a watchdog-only release is an error
                        bus.timeout_err  <= !bus.trans_done &&
                                            !bus.slave_split;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fair_bus_arbiter.sv
// Randomized scoreboard bench for fair_bus_arbiter against a
// tenure-level reference model.
module tb_fair_bus_arbiter;
    localparam int TO = 8;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    fair_bus_arbiter_if bus ();

    fair_bus_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];

    // Reference model: owner, frozen slave, tenure age, starve count
    logic [1:0] own = 2'd0;
    logic [1:0] sel = 2'd0;
    int         age = 0;
    int         starve = 0;
    logic       terr = 1'b0;

    function automatic logic [7:0] dut_out();
        return {bus.m1_grant, bus.m2_grant, bus.arbiter_busy,
                bus.bus_grant, bus.slave_sel, bus.timeout_err};
    endfunction

    function automatic logic [7:0] model_out();
        return {own == 2'd1, own == 2'd2, own != 2'd0, own, sel, terr};
    endfunction

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        own = 2'd0;
        sel = 2'd0;
        age = 0;
        starve = 0;
        terr = 1'b0;
    endtask

    task automatic model_step(input logic r1, input logic r2,
                              input logic [1:0] s1, input logic [1:0] s2,
                              input logic td, input logic sp);
        terr = 1'b0;
        if (own == 2'd0) begin
            if (r2 && (!r1 || starve == SL)) begin
                own = 2'd2;
                sel = s2;
                starve = 0;
                age = 0;
            end else if (r1) begin
                own = 2'd1;
                sel = s1;
                age = 0;
                if (r2 && starve < SL) starve++;
            end
        end else begin
            age++;
            if (td || sp || age == TO) begin
                terr = (age == TO) && !td && !sp;
                own = 2'd0;
                sel = 2'd0;
            end
        end
    endtask

    task automatic drive(input logic r1, input logic r2,
                         input logic [1:0] s1, input logic [1:0] s2,
                         input logic td, input logic sp);
        bus.m1_request   = r1;
        bus.m2_request   = r2;
        bus.m1_slave_sel = s1;
        bus.m2_slave_sel = s2;
        bus.trans_done   = td;
        bus.slave_split  = sp;
        model_step(r1, r2, s1, s2, td, sp);
        exp_q.push_back(model_out());
    endtask

    task automatic cyc(input logic r1, input logic r2,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic td, input logic sp);
        @(negedge clk);
        drive(r1, r2, s1, s2, td, sp);
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", dut_out(), e);
                check("onehot", {7'd0, bus.m1_grant & bus.m2_grant}, 8'd0);
            end
        end
    end

    initial begin
        bus.m1_request   = 1'b0;
        bus.m2_request   = 1'b0;
        bus.m1_slave_sel = 2'd0;
        bus.m2_slave_sel = 2'd0;
        bus.trans_done   = 1'b0;
        bus.slave_split  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", dut_out(), 8'd0);
        rst_n = 1'b1;

        // Single master-2 tenure, four cycles long
        cyc(0, 1, 0, 3, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);

        // Priority then starvation guard: m1 x4, m2, m1
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 1, 2, 0, 0);
            cyc(1, 1, 1, 2, 1, 0);
        end
        repeat (2) cyc(0, 0, 0, 0, 0, 0);

        // Watchdog expiry, then done coinciding with the last cycle
        cyc(1, 0, 2, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2, 0, 0, 0);
        repeat (7) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);

        // Frozen selection during OWN2, released by split
        cyc(0, 1, 0, 2, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(1, 0, 3, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-tenure
        cyc(1, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", dut_out(), 8'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 99) < 18, $urandom_range(0, 99) < 5);
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0)
            check("drain", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
